// File: rtl/nic8_sequencer.sv
// nic8_sequencer: four-state control sequencer for the NIC8 datapath.
// The sequencer fetches an instruction in one cycle and executes it in the next.
// It can free-run, or single-step on a fresh rising stepReq.
// The control bits decode the registered state. The decode also uses the IR fields
// and the ALU flags, because those inputs are only meaningful during EXEC.
module nic8_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       ir,
  input  logic             zeroFlag,
  input  logic             carryFlag,
  input  logic             run,
  input  logic             stepReq,
  output logic             stepAck,
  output logic [13:0]      controlBits,
  output logic             incPC,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  // Field order matches the controlBits bus, MSB first.
  typedef struct packed {
    logic load_ir;
    logic load_pc;
    logic load_a;
    logic load_b;
    logic load_x;
    logic do_out;
    logic store_mem;
    logic assert_m;
    logic assert_e;
    logic assert_a;
    logic assert_x;
    logic immediate;
    logic do_subtract;
    logic do_jump;
  } ctrl_t;

  state_t     state;
  ctrl_t      ctrl;
  logic       step_armed;   // stepReq has been seen low since the last step started
  logic       stepped;      // current instruction was started by a single-step request
  logic       jump_taken;

  logic [1:0] src;
  logic [2:0] dst;
  logic       imm;
  logic       sub;
  logic       hlt;

  assign src = ir[7:6];
  assign dst = ir[5:3];
  assign imm = ir[2];
  assign sub = ir[1];
  assign hlt = ir[0];

  // Sequencer state, step qualifier, retire counter and the step acknowledge pulse.
  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      step_armed <= 1'b0;
      stepped    <= 1'b0;
      stepAck    <= 1'b0;
      retired    <= '0;
    end else begin
      stepAck <= 1'b0;
      if (!stepReq) step_armed <= 1'b1;
      case (state)
        IDLE: begin
          if (run) begin
            state   <= FETCH;
            stepped <= 1'b0;
          end else if (stepReq && step_armed) begin
            state      <= FETCH;
            stepped    <= 1'b1;
            step_armed <= 1'b0;
          end
        end
        FETCH: state <= EXEC;
        EXEC: begin
          retired <= retired + 1'b1;
          if (hlt) begin
            state <= HALT;
          end else if (run) begin
            state   <= FETCH;
            stepped <= 1'b0;
          end else begin
            state   <= IDLE;
            stepAck <= stepped;   // free-run stopped by run=0 gets no acknowledge
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Decode the control word from the state and, during EXEC, from the instruction fields.
  // NOTE: defaults at the top of the block keep every path assigned, so no latches.
  always_comb begin
    ctrl       = '0;
    incPC      = 1'b0;
    jump_taken = 1'b0;
    case (state)
      FETCH: begin
        ctrl.assert_m  = 1'b1;
        ctrl.immediate = 1'b1;
        ctrl.load_ir   = 1'b1;
        incPC          = 1'b1;
      end
      EXEC: begin
        case (src)
          2'd0: ctrl.assert_m = 1'b1;
          2'd1: ctrl.assert_e = 1'b1;
          2'd2: ctrl.assert_a = 1'b1;
          2'd3: ctrl.assert_x = 1'b1;
          default: ;
        endcase
        case (dst)
          3'd0: ctrl.load_a    = 1'b1;
          3'd1: ctrl.load_b    = 1'b1;
          3'd2: ctrl.load_x    = 1'b1;
          3'd3: ctrl.do_out    = 1'b1;
          3'd4: ctrl.store_mem = (src != 2'd0);   // M-to-M is a no-op
          3'd5: jump_taken     = 1'b1;
          3'd6: jump_taken     = zeroFlag;
          3'd7: jump_taken     = carryFlag;
          default: ;
        endcase
        ctrl.immediate   = imm;
        ctrl.do_subtract = sub;
        ctrl.load_pc     = jump_taken;
        ctrl.do_jump     = jump_taken;
        incPC            = imm & ~jump_taken;   // a taken jump overrides the increment
      end
      default: ;
    endcase
  end

  assign controlBits = ctrl;
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_nic8_sequencer.sv
// tb_nic8_sequencer: randomized and directed checks of nic8_sequencer against
// an instruction-level reference model. A 4-bit counter instance covers wrap-around.
module tb_nic8_sequencer;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_EXEC  = 2;
  localparam int P_HALT  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  ir;
  logic        zero_flag, carry_flag, run, step_req;
  logic        step_ack, inc_pc, halted;
  logic [13:0] control_bits;
  logic [15:0] retired;
  logic        step_ack4, inc_pc4, halted4;
  logic [13:0] control_bits4;
  logic [3:0]  retired4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: instruction phase, retired count, step bookkeeping.
  int m_phase;
  int m_retired;
  bit m_armed, m_stepped, m_ack;

  always #5 clk = ~clk;

  nic8_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .zeroFlag(zero_flag), .carryFlag(carry_flag),
    .run(run), .stepReq(step_req), .stepAck(step_ack), .controlBits(control_bits),
    .incPC(inc_pc), .halted(halted), .retired(retired)
  );

  nic8_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .ir(ir), .zeroFlag(zero_flag), .carryFlag(carry_flag),
    .run(run), .stepReq(step_req), .stepAck(step_ack4), .controlBits(control_bits4),
    .incPC(inc_pc4), .halted(halted4), .retired(retired4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit taken(input logic [7:0] i, input logic z, input logic c);
    int d = int'(i[5:3]);
    return (d == 5) || (d == 6 && z) || (d == 7 && c);
  endfunction

  // Control word built from bit positions of the 14-bit bus (loadIR = bit 13 ... doJump = bit 0).
  function automatic logic [13:0] exp_ctrl(input int ph, input logic [7:0] i,
                                           input logic z, input logic c);
    logic [13:0] v = '0;
    int s = int'(i[7:6]);
    int d = int'(i[5:3]);
    if (ph == P_FETCH) v = 14'h2044;
    if (ph == P_EXEC) begin
      v[6 - s] = 1'b1;
      if (d < 4) v[11 - d] = 1'b1;
      if (d == 4 && s != 0) v[7] = 1'b1;
      if (taken(i, z, c)) begin
        v[12] = 1'b1;
        v[0]  = 1'b1;
      end
      v[2] = i[2];
      v[1] = i[1];
    end
    return v;
  endfunction

  function automatic logic exp_inc(input int ph, input logic [7:0] i,
                                   input logic z, input logic c);
    if (ph == P_FETCH) return 1'b1;
    if (ph == P_EXEC)  return i[2] && !taken(i, z, c);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_retired = 0;
    m_armed   = 0;
    m_stepped = 0;
    m_ack     = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    bit ack_next = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (run) begin
          m_phase = P_FETCH; m_stepped = 0;
        end else if (step_req && m_armed) begin
          m_phase = P_FETCH; m_stepped = 1; m_armed = 0;
        end
      end
      P_FETCH: m_phase = P_EXEC;
      P_EXEC: begin
        m_retired++;
        if (ir[0])    m_phase = P_HALT;
        else if (run) begin m_phase = P_FETCH; m_stepped = 0; end
        else begin m_phase = P_IDLE; ack_next = m_stepped; end
      end
      default: ;
    endcase
    if (!step_req) m_armed = 1;
    m_ack = ack_next;
  endtask

  // Compare every output at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check("ctrl",     32'(control_bits), 32'(exp_ctrl(m_phase, ir, zero_flag, carry_flag)));
    check("incPC",    32'(inc_pc),       32'(exp_inc(m_phase, ir, zero_flag, carry_flag)));
    check("stepAck",  32'(step_ack),     32'(m_ack));
    check("halted",   32'(halted),       32'(m_phase == P_HALT));
    check("retired",  32'(retired),      32'(m_retired % 65536));
    check("retired4", 32'(retired4),     32'(m_retired % 16));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    run = 0; step_req = 0;
    reset_n = 0;
    #1;
    model_reset();
    check("rst_ctrl",    32'(control_bits), 32'h0);
    check("rst_retired", 32'(retired),      32'h0);
    tick();
    tick();
    reset_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acks;
    reset_n = 0; ir = 8'h00; zero_flag = 0; carry_flag = 0; run = 0; step_req = 0;
    model_reset();
    @(posedge clk); #1;
    apply_reset();

    // Free-run: A->A then M,imm->X; outputs alternate fetch/exec.
    run = 1; ir = 8'h80;
    tick(); tick(); tick();
    ir = 8'h14;
    tick();
    check("fr_exec_ctrl", 32'(control_bits), 32'h0244);
    check("fr_exec_inc",  32'(inc_pc), 32'h1);
    tick();
    check("fr_retired2",  32'(retired), 32'd2);
    run = 0;
    tick(); tick();
    check("run_drop_noack", 32'(step_ack), 32'h0);
    tick();

    // Conditional jump on carry with immediate.
    apply_reset();
    run = 1; ir = 8'hFC; carry_flag = 0;
    tick(); tick();
    check("jc0_ctrl", 32'(control_bits), 32'h000C);
    check("jc0_inc",  32'(inc_pc), 32'h1);
    tick();
    carry_flag = 1;
    tick();
    check("jc1_ctrl", 32'(control_bits), 32'h100D);
    check("jc1_inc",  32'(inc_pc), 32'h0);
    run = 0; carry_flag = 0;
    tick(); tick();

    // Single-step with stepReq held high: exactly one instruction.
    apply_reset();
    ir = 8'h48;
    tick();
    step_req = 1; acks = 0;
    repeat (10) begin
      tick();
      acks += int'(step_ack);
    end
    check("step_acks",    32'(acks), 32'd1);
    check("step_retired", 32'(retired), 32'd1);
    step_req = 0;
    tick();
    step_req = 1;
    repeat (4) tick();
    check("step2_retired", 32'(retired), 32'd2);
    step_req = 0;
    tick();

    // Halt: held until reset regardless of run/stepReq.
    apply_reset();
    run = 1; ir = 8'h01;
    tick(); tick(); tick();
    check("halt_flag", 32'(halted), 32'h1);
    repeat (20) begin
      step_req = ~step_req;
      ir = 8'($urandom);
      tick();
    end
    check("halt_retired", 32'(retired), 32'd1);
    check("halt_ctrl",    32'(control_bits), 32'h0);
    step_req = 0;

    // Reset asserted during EXEC of the illegal M->M instruction.
    apply_reset();
    run = 1; ir = 8'h20;
    tick(); tick();
    check("mm_exec_ctrl", 32'(control_bits), 32'h0040);
    #2 reset_n = 0;
    #1;
    model_reset();
    check("abort_ctrl",    32'(control_bits), 32'h0);
    check("abort_inc",     32'(inc_pc), 32'h0);
    check("abort_retired", 32'(retired), 32'h0);
    check("abort_halted",  32'(halted), 32'h0);
    tick(); tick();
    reset_n = 1;
    tick(); tick();
    check("mm_nostore", 32'(control_bits[7]), 32'h0);
    tick();
    check("mm_retired", 32'(retired), 32'd1);
    run = 0;
    tick(); tick();

    // Sixteen free-run instructions wrap the 4-bit counter.
    apply_reset();
    run = 1; ir = 8'h80;
    tick();
    repeat (32) tick();
    check("wrap4",  32'(retired4), 32'h0);
    check("wrap16", 32'(retired),  32'd16);
    run = 0;
    tick(); tick();

    // Randomized traffic: mixed run/step modes, random instructions and flags.
    apply_reset();
    for (int blk = 0; blk < 40; blk++) begin
      bit mode_run = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 20; k++) begin
        run        = mode_run ? ($urandom_range(0, 9) != 0) : 1'b0;
        step_req   = 1'($urandom_range(0, 1));
        ir         = 8'($urandom) & 8'hFE;
        zero_flag  = 1'($urandom_range(0, 1));
        carry_flag = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
